// File: rtl/alu_mul_sequencer.sv
// Multi-cycle MUL controller: borrows the EXE-stage ALU for a shift-and-add loop,
// stalling the pipeline while busy and returning the low N bits of the product with N/Z flags.
module alu_mul_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         startIn,
    input  logic         abortIn,
    input  logic [N-1:0] Val1In,
    input  logic [N-1:0] Val2In,
    input  logic [N-1:0] aluResIn,
    output logic [N-1:0] aluVal1Out,
    output logic [N-1:0] aluVal2Out,
    output logic [3:0]   aluCmdOut,
    output logic         busyOut,
    output logic         readyOut,
    output logic         doneOut,
    output logic [N-1:0] resultOut,
    output logic [1:0]   nzOut
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_NOP = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   acc;
    logic [CW-1:0]  count;
    logic           busy;
    logic           ready;
    logic           done;
    logic [N-1:0]   result;
    logic [1:0]     nz;

    logic [N-1:0]   mplier_next;
    logic           last_step;

    // The count limit can only coincide with the multiplier running out of bits.
    assign mplier_next = mplier >> 1;
    assign last_step   = (mplier_next == '0) || (count == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            nz     <= 2'b01;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!abortIn && startIn) begin
                        mcand  <= Val1In;
                        mplier <= Val2In;
                        acc    <= '0;
                        count  <= '0;
                        ready  <= 1'b0;
                        if (Val2In == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= '0;
                            nz     <= 2'b01;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abortIn) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else begin
                        acc    <= aluResIn;
                        mcand  <= mcand << 1;
                        mplier <= mplier_next;
                        count  <= count + 1'b1;
                        if (last_step) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= aluResIn;
                            nz     <= {aluResIn[N-1], aluResIn == '0};
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // ALU operands are decoded purely from registered state, never from inputs.
    always_comb begin
        aluVal1Out = '0;
        aluVal2Out = '0;
        aluCmdOut  = ALU_NOP;
        if (state == RUN) begin
            aluVal1Out = acc;
            aluVal2Out = mplier[0] ? mcand : '0;
            aluCmdOut  = ALU_ADD;
        end
    end

    assign busyOut   = busy;
    assign readyOut  = ready;
    assign doneOut   = done;
    assign resultOut = result;
    assign nzOut     = nz;

    a_count_never_sole_exit: assert property (
        @(posedge clk) disable iff (rst)
        (state == RUN && count == CW'(N - 1)) |-> (mplier_next == '0)
    );

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them whenever doneOut pulses.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rst;
    logic        startIn;
    logic        abortIn;
    logic [31:0] Val1In;
    logic [31:0] Val2In;
    logic [31:0] aluResIn;
    logic [31:0] aluVal1Out;
    logic [31:0] aluVal2Out;
    logic [3:0]  aluCmdOut;
    logic        busyOut;
    logic        readyOut;
    logic        doneOut;
    logic [31:0] resultOut;
    logic [1:0]  nzOut;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  nz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    alu_mul_sequencer #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .startIn    (startIn),
        .abortIn    (abortIn),
        .Val1In     (Val1In),
        .Val2In     (Val2In),
        .aluResIn   (aluResIn),
        .aluVal1Out (aluVal1Out),
        .aluVal2Out (aluVal2Out),
        .aluCmdOut  (aluCmdOut),
        .busyOut    (busyOut),
        .readyOut   (readyOut),
        .doneOut    (doneOut),
        .resultOut  (resultOut),
        .nzOut      (nzOut)
    );

    // Combinational EXE-stage ALU model: only ADD is ever requested.
    assign aluResIn = (aluCmdOut == 4'b0010) ? aluVal1Out + aluVal2Out : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},  32'(busyOut),  32'd0);
        checkOutput({tag, "_ready"}, 32'(readyOut), 32'd1);
        checkOutput({tag, "_done"},  32'(doneOut),  32'd0);
        checkOutput({tag, "_result"}, resultOut,    32'h0);
        checkOutput({tag, "_nz"},    32'(nzOut),    32'd1);
        checkOutput({tag, "_cmd"},   32'(aluCmdOut), 32'd0);
        checkOutput({tag, "_v1"},    aluVal1Out,    32'h0);
        checkOutput({tag, "_v2"},    aluVal2Out,    32'h0);
    endtask

    // Must be called at a negedge; returns at a negedge with readyOut high.
    task automatic waitReady();
        int n = 0;
        while (readyOut !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (readyOut !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL ready_timeout: actual=%b required=1", readyOut);
        end
    endtask

    // Issues a start in the current cycle (cycle 0) and returns at the negedge of cycle 1.
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_res, input logic [1:0] exp_nz,
                                 input int k, input bit push);
        exp_t e;
        waitReady();
        startIn = 1'b1;
        Val1In  = a;
        Val2In  = b;
        if (push) begin
            e.res  = exp_res;
            e.nz   = exp_nz;
            e.cyc  = cyc + k + 1;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        startIn = 1'b0;
    endtask

    // Monitor: every doneOut pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (doneOut === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: actual=done at cycle %0d required=no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_result"}, resultOut, e.res);
                checkOutput({e.name, "_nz"}, 32'(nzOut), 32'(e.nz));
                checkOutput({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst     = 1'b1;
        startIn = 1'b0;
        abortIn = 1'b0;
        Val1In  = '0;
        Val2In  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("reset");

        // 3 x 5: RUN cycles 1..3, done in 4, ready in 5
        applyStimulus("mul3x5", 32'd3, 32'd5, 32'd15, 2'b00, 3, 1'b1);
        checkOutput("c1_busy", 32'(busyOut), 32'd1);
        checkOutput("c1_cmd",  32'(aluCmdOut), 32'd2);
        checkOutput("c1_v1",   aluVal1Out, 32'd0);
        checkOutput("c1_v2",   aluVal2Out, 32'd3);
        @(negedge clk);
        checkOutput("c2_v2",   aluVal2Out, 32'd0);
        checkOutput("c2_busy", 32'(busyOut), 32'd1);
        @(negedge clk);
        checkOutput("c3_v1",   aluVal1Out, 32'd3);
        checkOutput("c3_v2",   aluVal2Out, 32'd12);
        @(negedge clk);
        checkOutput("c4_busy",  32'(busyOut), 32'd0);
        checkOutput("c4_ready", 32'(readyOut), 32'd0);
        @(negedge clk);
        checkOutput("c5_ready", 32'(readyOut), 32'd1);
        checkOutput("c5_done",  32'(doneOut), 32'd0);

        applyStimulus("mul_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32, 1'b1);

        // Zero multiplier goes straight to DONE without touching the ALU
        applyStimulus("mul7x0", 32'd7, 32'd0, 32'd0, 2'b01, 0, 1'b1);
        checkOutput("zero_cmd",  32'(aluCmdOut), 32'd0);
        checkOutput("zero_busy", 32'(busyOut), 32'd0);

        applyStimulus("wrap", 32'h8000_0000, 32'd2, 32'h0, 2'b01, 2, 1'b1);
        applyStimulus("neg3x4", 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 2'b10, 3, 1'b1);

        // Abort in cycle 4 of a 9 x 0xFF multiply
        applyStimulus("abort", 32'd9, 32'hFF, 32'h0, 2'b00, 8, 1'b0);
        repeat (3) @(negedge clk);
        abortIn = 1'b1;
        @(negedge clk);
        abortIn = 1'b0;
        checkOutput("abort_ready",  32'(readyOut), 32'd1);
        checkOutput("abort_busy",   32'(busyOut), 32'd0);
        checkOutput("abort_result", resultOut, 32'hFFFF_FFF4);
        checkOutput("abort_nz",     32'(nzOut), 32'd2);
        applyStimulus("after_abort", 32'd9, 32'hFF, 32'h0000_08F7, 2'b00, 8, 1'b1);

        // A second start during RUN/DONE must be dropped
        applyStimulus("mul6x7", 32'd6, 32'd7, 32'd42, 2'b00, 3, 1'b1);
        @(negedge clk);
        startIn = 1'b1;
        Val1In  = 32'd100;
        Val2In  = 32'd100;
        repeat (2) @(negedge clk);
        startIn = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("ignored_start_ready", 32'(readyOut), 32'd1);

        // Reset in cycle 3 of a 32-step multiply
        applyStimulus("rst_mid", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 2'b00, 32, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("rst_mid");

        applyStimulus("mul12x12", 32'd12, 32'd12, 32'd144, 2'b00, 4, 1'b1);

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: actual=%0d pending required=0", sb.size());
        end
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle multiply controller that implements the ARM `MUL` instruction by borrowing the EXE-stage ALU. It runs a shift-and-add loop, issuing one ADD command per cycle, and the execute stage hands the shared ALU to this block while `busyOut` is high. The block stalls the pipeline during the loop and returns the low N bits of the product along with N/Z flags.

## Interface
- `N`, 32: operand, product and ALU datapath width.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `startIn`  in  1: request a multiply. Sampled only in IDLE.
- `abortIn`  in  1: pipeline flush. Cancels the operation in progress.
- `Val1In`  in  N: multiplicand (Rm).
- `Val2In`  in  N: multiplier (Rs).
- `aluResIn`  in  N: result returned by the shared ALU.
- `aluVal1Out`  out  N: ALU operand 1, the running accumulator.
- `aluVal2Out`  out  N: ALU operand 2, the shifted multiplicand or 0.
- `aluCmdOut`  out  4: ALU command, `4'b0010` (ADD) in RUN, otherwise `4'b0000`.
- `busyOut`  out  1: high in RUN. Drives the pipeline stall and the ALU operand mux select.
- `readyOut`  out  1: high in IDLE.
- `doneOut`  out  1: one-cycle pulse when the result is valid.
- `resultOut`  out  N: product mod 2^N. Held until the next accepted start.
- `nzOut`  out  2: {N, Z} flags of `resultOut`. C and V are not produced, because ARM MUL leaves them unaffected.

## Operation
- States and transitions:
  - IDLE: `startIn` goes to RUN, or straight to DONE if `Val2In == 0`.
  - RUN: goes to DONE once the next multiplier register value is 0.
  - DONE: always goes to IDLE after one cycle.
- Registers:
  - `mcand` (N bits), `mplier` (N bits), `acc` (N bits).
  - `count`: 6 bits for N = 32, ceil(log2 N)+1 in general.
  - state, `resultOut`, `nzOut`.
- On an accepted start:
  - `mcand <= Val1In`, `mplier <= Val2In`, `acc <= 0`, `count <= 0`.
- Each RUN cycle:
  - Drives `aluVal1Out = acc`, `aluVal2Out = mplier[0] ? mcand : 0`, `aluCmdOut = ADD`.
  - Then `acc <= aluResIn`, `mcand <= mcand << 1`, `mplier <= mplier >> 1`, `count <= count + 1`.
- Termination:
  - RUN ends when `(mplier >> 1) == 0`.
  - `count` equal to N-1 is a hard stop. It is redundant by construction, and an assertion checks that it is never the sole exit.
- Entering DONE:
  - `resultOut <= acc` is loaded with the final ADD result, i.e. `aluResIn` of the last RUN cycle, or 0 on the zero-multiplier path.
  - `nzOut <= {result[N-1], result == 0}`.
- Arithmetic:
  - Unsigned shift-add. The low N bits equal the signed product, so no sign handling is needed.
  - ALU carry and overflow are ignored. Bits shifted past N-1 are discarded.
- Start rules:
  - `startIn` in RUN or DONE is ignored and not queued.
  - The requester must hold `startIn` until it sees `readyOut`.
- Abort:
  - `abortIn` in RUN or DONE forces IDLE on the next edge.
  - `doneOut` is not pulsed, and `resultOut`/`nzOut` are not updated.
  - `abortIn` in IDLE has priority over `startIn`, so the start is dropped.
- Outside RUN: `aluCmdOut = 0000`, `aluVal1Out = 0`, `aluVal2Out = 0`.

## Timing
- Reset values:
  - State IDLE; `busyOut` 0, `readyOut` 1, `doneOut` 0.
  - `resultOut` 0, `nzOut` 2'b01.
  - All internal registers 0; ALU outputs 0 / `0000`.
- Reset mid-operation returns to IDLE on that edge with no `doneOut` pulse.
- Latency, with the start accepted in cycle 0:
  - RUN occupies cycles 1..k, where k = (index of the most significant set bit of `Val2In`) + 1, range 1..N.
  - DONE, `doneOut` = 1 and `resultOut` valid, in cycle k+1.
  - Back in IDLE, ready again, in cycle k+2.
  - Zero multiplier: DONE in cycle 1.
- ALU path:
  - The ALU is combinational, so `aluResIn` is consumed in the same cycle the operands are driven.
  - All operand and command outputs are decoded from registers only, with no path from inputs to outputs.
- `busyOut` rises in cycle 1 and falls in the DONE cycle, so the stalled instruction advances together with `doneOut`.

## Test plan
- 3 × 5 (`Val2In` = 5): RUN for 3 cycles; `doneOut` in cycle 4; `resultOut` = 15, `nzOut` = 00; `readyOut` in cycle 5.
- 0xFFFFFFFF × 0xFFFFFFFF: RUN for 32 cycles; `doneOut` in cycle 33; `resultOut` = 0x00000001.
- 7 × 0: no RUN cycles, `aluCmdOut` stays `0000`; `doneOut` in cycle 1; `resultOut` = 0, `nzOut` = 01.
- 0x80000000 × 2: `resultOut` = 0 with `nzOut` = 01 (wrap); then -3 × 4 (0xFFFFFFFD × 4) gives 0xFFFFFFF4, `nzOut` = 10.
- Start 9 × 0xFF, assert `abortIn` in cycle 4: IDLE in cycle 5, no `doneOut`, `resultOut` keeps its previous value; a new start in cycle 5 completes normally.
- Second `startIn` during RUN is ignored, and exactly one `doneOut` is seen. `rst` in cycle 3 of a 32-step multiply: all outputs return to their reset values the next cycle.
